// File: rtl/prbs_pkg.sv
`default_nettype none
// ============================================================================
// Module   : prbs_pkg
// Brief    : Shared PRBS types and helpers (Galois step, popcount).
// Revision : 1.0 - initial release
// ============================================================================
package prbs_pkg;

    typedef enum logic [1:0] {
        HUNT = 2'd0,
        SYNC = 2'd1,
        LOCK = 2'd2
    } prbs_state_e;

    // Helpers work on a 64-bit container; callers zero-extend narrower words.
    localparam int c_PRBS_MAX_W = 64;
    localparam int c_POP_W      = 7;

    // One Galois advance; the top stage always feeds back, POLY's MSB is ignored.
    function automatic logic [c_PRBS_MAX_W-1:0] prbs_galois_step(
        input logic [c_PRBS_MAX_W-1:0] q,
        input logic [c_PRBS_MAX_W-1:0] poly,
        input int                      width
    );
        logic [c_PRBS_MAX_W-1:0] taps;
        for (int i = 0; i < c_PRBS_MAX_W; i++) begin
            if (i == width - 1)
                taps[i] = 1'b1;
            else if (i < width - 1)
                taps[i] = poly[i];
            else
                taps[i] = 1'b0;
        end
        return (q >> 1) ^ (q[0] ? taps : '0);
    endfunction

    function automatic logic [c_POP_W-1:0] prbs_popcount(
        input logic [c_PRBS_MAX_W-1:0] v
    );
        logic [c_POP_W-1:0] n;
        n = '0;
        for (int i = 0; i < c_PRBS_MAX_W; i++)
            n = n + c_POP_W'(v[i]);
        return n;
    endfunction

endpackage
`default_nettype wire

// File: rtl/prbs_chk_sat_acc.sv
`default_nettype none
// ============================================================================
// Module   : prbs_sat_acc
// Brief    : Saturating accumulator with same-cycle clear-and-add.
// Revision : 1.0 - initial release
// ============================================================================
module prbs_sat_acc #(
    parameter int WIDTH     = 32,
    parameter int INC_WIDTH = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_clr,
    input  logic                 i_en,
    input  logic [INC_WIDTH-1:0] i_inc,
    output logic [WIDTH-1:0]     o_acc
);

    localparam int c_SUM_W = ((WIDTH > INC_WIDTH) ? WIDTH : INC_WIDTH) + 1;
    localparam logic [c_SUM_W-1:0] c_MAX = c_SUM_W'({WIDTH{1'b1}});

    logic [WIDTH-1:0]   r_acc;
    logic [WIDTH-1:0]   w_base;
    logic [WIDTH-1:0]   w_acc_nxt;
    logic [c_SUM_W-1:0] w_sum;

    // A clear restarts from zero but still keeps this cycle's increment.
    always_comb begin
        w_base    = i_clr ? '0 : r_acc;
        w_sum     = c_SUM_W'(w_base) + c_SUM_W'(i_inc);
        w_acc_nxt = w_base;
        if (i_en)
            w_acc_nxt = (w_sum > c_MAX) ? {WIDTH{1'b1}} : w_sum[WIDTH-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst)
            r_acc <= '0;
        else
            r_acc <= w_acc_nxt;
    end

    assign o_acc = r_acc;

endmodule
`default_nettype wire

// File: rtl/prbs_chk.sv
`default_nettype none
// ============================================================================
// Module   : prbs_chk
// Brief    : Self-synchronising Galois PRBS checker with error statistics.
// Revision : 1.0 - initial release
// ============================================================================
module prbs_chk
    import prbs_pkg::*;
#(
    parameter int                    DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] POLY       = '0,
    parameter int                    LOCK_CNT   = 8,
    parameter int                    UNLOCK_CNT = 4,
    parameter int                    CNT_WIDTH  = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  vld_i,
    input  logic [DATA_WIDTH-1:0] dat_i,
    input  logic                  clr_i,
    output logic                  lock_o,
    output logic                  err_o,
    output logic [CNT_WIDTH-1:0]  word_cnt_o,
    output logic [CNT_WIDTH-1:0]  err_cnt_o,
    output logic [CNT_WIDTH-1:0]  bit_err_cnt_o
);

    localparam int c_RUN_MAX = (LOCK_CNT > UNLOCK_CNT) ? LOCK_CNT : UNLOCK_CNT;
    localparam int c_RUN_W   = $clog2(c_RUN_MAX + 1);
    localparam logic [c_RUN_W-1:0] c_LOCK_RUN   = c_RUN_W'(LOCK_CNT);
    localparam logic [c_RUN_W-1:0] c_UNLOCK_RUN = c_RUN_W'(UNLOCK_CNT);

    prbs_state_e             r_state, w_state_nxt;
    logic [DATA_WIDTH-1:0]   r_exp, w_exp_nxt;
    logic [c_RUN_W-1:0]      r_run, w_run_nxt, w_run_inc;
    logic                    r_err, w_err_nxt;

    logic [c_PRBS_MAX_W-1:0] w_step_dat_full, w_step_exp_full;
    logic [DATA_WIDTH-1:0]   w_step_dat, w_step_exp;
    logic [c_POP_W-1:0]      w_pop;
    logic                    w_match, w_dat_nz;
    logic                    w_word_en, w_err_en;
    logic                    w_unused;

    assign w_step_dat_full = prbs_galois_step(c_PRBS_MAX_W'(dat_i), c_PRBS_MAX_W'(POLY), DATA_WIDTH);
    assign w_step_exp_full = prbs_galois_step(c_PRBS_MAX_W'(r_exp), c_PRBS_MAX_W'(POLY), DATA_WIDTH);
    assign w_step_dat      = w_step_dat_full[DATA_WIDTH-1:0];
    assign w_step_exp      = w_step_exp_full[DATA_WIDTH-1:0];
    assign w_pop           = prbs_popcount(c_PRBS_MAX_W'(dat_i ^ r_exp));
    assign w_match         = (dat_i == r_exp);
    assign w_dat_nz        = |dat_i;
    assign w_run_inc       = r_run + 1'b1;

    // Upper bits of the 64-bit helper results are always zero.
    assign w_unused = ^{w_step_dat_full, w_step_exp_full};

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= HUNT;
            r_exp   <= '0;
            r_run   <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_exp   <= w_exp_nxt;
            r_run   <= w_run_nxt;
            r_err   <= w_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_exp_nxt   = r_exp;
        w_run_nxt   = r_run;
        w_err_nxt   = 1'b0;
        if (vld_i) begin
            case (r_state)
                HUNT: begin
                    // All-zero is the LFSR lockup word and can never seed.
                    if (w_dat_nz) begin
                        w_exp_nxt   = w_step_dat;
                        w_run_nxt   = '0;
                        w_state_nxt = SYNC;
                    end
                end
                SYNC: begin
                    w_exp_nxt = w_step_dat;
                    w_run_nxt = '0;
                    if (w_match) begin
                        w_run_nxt = w_run_inc;
                        if (w_run_inc == c_LOCK_RUN) begin
                            w_run_nxt   = '0;
                            w_state_nxt = LOCK;
                        end
                    end else if (!w_dat_nz) begin
                        w_state_nxt = HUNT;
                    end
                end
                LOCK: begin
                    // Flywheel: the model advances on its own, never from data.
                    w_exp_nxt = w_step_exp;
                    w_run_nxt = '0;
                    if (!w_match) begin
                        w_err_nxt = 1'b1;
                        w_run_nxt = w_run_inc;
                        if (w_run_inc == c_UNLOCK_RUN) begin
                            w_run_nxt   = '0;
                            w_state_nxt = HUNT;
                        end
                    end
                end
                default: w_state_nxt = HUNT;
            endcase
        end
    end

    always_comb begin
        w_word_en = vld_i && (r_state == LOCK);
        w_err_en  = w_word_en && !w_match;
        lock_o    = (r_state == LOCK);
        err_o     = r_err;
    end

    prbs_sat_acc #(.WIDTH(CNT_WIDTH), .INC_WIDTH(1)) u_word_cnt (
        .clk   (clk_i),
        .rst   (rst_i),
        .i_clr (clr_i),
        .i_en  (w_word_en),
        .i_inc (1'b1),
        .o_acc (word_cnt_o)
    );

    prbs_sat_acc #(.WIDTH(CNT_WIDTH), .INC_WIDTH(1)) u_err_cnt (
        .clk   (clk_i),
        .rst   (rst_i),
        .i_clr (clr_i),
        .i_en  (w_err_en),
        .i_inc (1'b1),
        .o_acc (err_cnt_o)
    );

    prbs_sat_acc #(.WIDTH(CNT_WIDTH), .INC_WIDTH(c_POP_W)) u_bit_err_cnt (
        .clk   (clk_i),
        .rst   (rst_i),
        .i_clr (clr_i),
        .i_en  (w_err_en),
        .i_inc (w_pop),
        .o_acc (bit_err_cnt_o)
    );

endmodule
`default_nettype wire

// File: tb/tb_prbs_chk.sv
`default_nettype none
// ============================================================================
// Module   : tb_prbs_chk
// Brief    : Directed self-checking bench for prbs_chk (8-bit, POLY=B8).
// Revision : 1.0 - initial release
// ============================================================================
module tb_prbs_chk;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       vld = 1'b0;
    logic [7:0] dat = 8'h00;
    logic       clr = 1'b0;

    logic        lock, err, lock_s, err_s;
    logic [31:0] wc, ec, bc;
    logic [3:0]  wc_s, ec_s, bc_s;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    // Generator sequence starting from 01, worked out by hand.
    logic [7:0] seq [0:26] = '{8'h01, 8'hB8, 8'h5C, 8'h2E, 8'h17, 8'hB3, 8'hE1,
                               8'hC8, 8'h64, 8'h32, 8'h19, 8'hB4, 8'h5A, 8'h2D,
                               8'hAE, 8'h57, 8'h93, 8'hF1, 8'hC0, 8'h60, 8'h30,
                               8'h18, 8'h0C, 8'h06, 8'h03, 8'hB9, 8'hE4};

    always #5 clk = ~clk;

    prbs_chk #(.DATA_WIDTH(8), .POLY(8'hB8), .LOCK_CNT(2), .UNLOCK_CNT(2), .CNT_WIDTH(32)) dut (
        .clk_i(clk), .rst_i(rst), .vld_i(vld), .dat_i(dat), .clr_i(clr),
        .lock_o(lock), .err_o(err), .word_cnt_o(wc), .err_cnt_o(ec), .bit_err_cnt_o(bc)
    );

    prbs_chk #(.DATA_WIDTH(8), .POLY(8'hB8), .LOCK_CNT(2), .UNLOCK_CNT(2), .CNT_WIDTH(4)) dut_s (
        .clk_i(clk), .rst_i(rst), .vld_i(vld), .dat_i(dat), .clr_i(clr),
        .lock_o(lock_s), .err_o(err_s), .word_cnt_o(wc_s), .err_cnt_o(ec_s), .bit_err_cnt_o(bc_s)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic check_main(input string tag, input logic l, input logic e,
                              input int w, input int ecnt, input int b);
        check({tag, ".lock"}, {31'd0, lock}, {31'd0, l});
        check({tag, ".err"},  {31'd0, err},  {31'd0, e});
        check({tag, ".word"}, wc, w);
        check({tag, ".errc"}, ec, ecnt);
        check({tag, ".bitc"}, bc, b);
    endtask

    task automatic send(input logic [7:0] d);
        vld = 1'b1;
        dat = d;
        @(posedge clk);
        #1;
        vld = 1'b0;
        dat = 8'h00;
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_rst();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        idle();
        idle();
        rst = 1'b0;
        check_main("reset", 1'b0, 1'b0, 0, 0, 0);
        check("reset.s_word", {28'd0, wc_s}, 0);

        // Clean lock with a gap inside the SYNC run.
        send(seq[0]);  check("lock_w0", {31'd0, lock}, 0);
        send(seq[1]);  check("lock_w1", {31'd0, lock}, 0);
        idle();        check("lock_gap", {31'd0, lock}, 0);
        send(seq[2]);  check_main("lock_w2", 1'b1, 1'b0, 0, 0, 0);
        send(seq[3]);  check_main("lock_w3", 1'b1, 1'b0, 1, 0, 0);

        // Single error: FF ^ 17 = E8 has four set bits.
        send(8'hFF);   check_main("single", 1'b1, 1'b1, 2, 1, 4);
        idle();        check("single_gap_err", {31'd0, err}, 0);
        send(seq[5]);  check_main("single_after", 1'b1, 1'b0, 3, 1, 4);

        // Non-consecutive errors keep lock; 8-bit errors clamp the 4-bit counter.
        send(~seq[6]); check_main("err8a", 1'b1, 1'b1, 4, 2, 12);
        check("err8a.s_bitc", {28'd0, bc_s}, 12);
        send(seq[7]);  check("err_gap_lock", {31'd0, lock}, 1);
        send(~seq[8]); check_main("err8b", 1'b1, 1'b1, 6, 3, 20);
        check("err8b.s_bitc", {28'd0, bc_s}, 15);
        check("err8b.s_errc", {28'd0, ec_s}, 3);

        // Second consecutive mismatch unlocks and is still counted.
        send(seq[9] ^ 8'h01); check_main("unlock", 1'b0, 1'b1, 7, 4, 21);
        check("unlock.s_word", {28'd0, wc_s}, 7);

        // Relock after three valid words; counters frozen outside LOCK.
        send(seq[10]); check("relock_w0", {31'd0, lock}, 0);
        send(seq[11]); check_main("relock_w1", 1'b0, 1'b0, 7, 4, 21);
        send(seq[12]); check_main("relock_w2", 1'b1, 1'b0, 7, 4, 21);

        // Saturation of the 4-bit word counter.
        for (int i = 13; i <= 20; i++) send(seq[i]);
        check("sat8.word", wc, 15);
        check("sat8.s_word", {28'd0, wc_s}, 15);
        send(seq[21]);
        send(seq[22]);
        check("sat10.word", wc, 17);
        check("sat10.s_word", {28'd0, wc_s}, 15);

        // Clear together with an increment keeps that increment.
        clr = 1'b1;
        send(seq[23]);
        check_main("clr_match", 1'b1, 1'b0, 1, 0, 0);
        check("clr_match.s_word", {28'd0, wc_s}, 1);
        send(~seq[24]);
        clr = 1'b0;
        check_main("clr_err", 1'b1, 1'b1, 1, 1, 8);
        check("clr_err.s_bitc", {28'd0, bc_s}, 8);
        send(seq[25]); check_main("clr_after", 1'b1, 1'b0, 2, 1, 8);

        // Reset wins over a valid word in LOCK.
        vld = 1'b1;
        dat = seq[26];
        pulse_rst();
        vld = 1'b0;
        check_main("rst_lock", 1'b0, 1'b0, 0, 0, 0);
        check("rst_lock.s_word", {28'd0, wc_s}, 0);
        send(seq[2]);  check("rst_relock_w0", {31'd0, lock}, 0);
        send(seq[3]);  check("rst_relock_w1", {31'd0, lock}, 0);
        send(seq[4]);  check("rst_relock_w2", {31'd0, lock}, 1);

        // Zeros never seed; a SYNC mismatch reseeds from the data (step(33)=A1).
        pulse_rst();
        send(8'h00);
        send(8'h00);
        send(8'h00);   check("zero_hunt", {31'd0, lock}, 0);
        send(8'h01);   check("seed_01", {31'd0, lock}, 0);
        send(8'h33);   check("reseed_33", {31'd0, lock}, 0);
        send(8'hA1);   check("reseed_A1", {31'd0, lock}, 0);
        send(8'hE8);   check_main("reseed_lock", 1'b1, 1'b0, 0, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
